// File: rtl/mmu_pkg.sv
// Shared types and defaults for the MMU / instruction / data memory arbiter.
package mmu_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTE  = 2'd1,
    DMEM = 2'd2,
    IMEM = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mmu_mem_arbiter.sv
// Three-way arbiter (PTE walker, data port, instruction port) onto a single
// memory port with one transaction outstanding and instruction-starvation relief.
module mmu_mem_arbiter
  import mmu_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pte_addr,
  input  logic          pte_read,
  output logic [31:0]   pte_rdata,
  output logic          pte_resp,
  input  logic [31:0]   i_addr,
  input  logic          i_read,
  output logic [31:0]   i_rdata,
  output logic          i_resp,
  input  logic [31:0]   d_addr,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wmask,
  output logic [31:0]   d_rdata,
  output logic          d_resp,
  output logic [31:0]   mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_resp,
  output logic [1:0]    dbg_state_o,
  output logic [SW-1:0] dbg_starve_cnt_o
);

  // Handshake: a requester holds its request until its one-cycle resp pulse and
  // drops it the cycle after; a request seen high in IDLE is a new transaction.
  // The memory side holds mem_read/mem_write stable until mem_resp is sampled.

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          write_q, write_d;

  logic starved;
  logic busy;

  assign starved = (starve_q == STARVE_MAX);
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    write_d  = write_q;
    case (state_q)
      IDLE: begin
        if (pte_read) begin
          state_d = PTE;
          addr_d  = {pte_addr[31:2], 2'b00};
          wdata_d = '0;
          wmask_d = '0;
          write_d = 1'b0;
        end else if (i_read && starved) begin
          state_d = IMEM;
          addr_d  = i_addr;
          wdata_d = '0;
          wmask_d = '0;
          write_d = 1'b0;
        end else if (d_read || d_write) begin
          state_d = DMEM;
          addr_d  = d_addr;
          wdata_d = d_write ? d_wdata : 32'h0;
          wmask_d = d_write ? d_wmask : 4'h0;
          write_d = d_write;
        end else if (i_read) begin
          state_d = IMEM;
          addr_d  = i_addr;
          wdata_d = '0;
          wmask_d = '0;
          write_d = 1'b0;
        end
        // With i_read high some port is always granted; only losses count.
        if (!i_read || state_d == IMEM) begin
          starve_d = '0;
        end else if (!starved) begin
          starve_d = starve_q + 1'b1;
        end
      end
      default: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      write_q  <= write_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_read  = busy && !write_q;
  assign mem_write = busy && write_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = mem_write ? wmask_q : 4'h0;

  assign pte_resp  = (state_q == PTE)  && mem_resp;
  assign d_resp    = (state_q == DMEM) && mem_resp;
  assign i_resp    = (state_q == IMEM) && mem_resp;
  assign pte_rdata = pte_resp ? mem_rdata : 32'h0;
  assign d_rdata   = d_resp   ? mem_rdata : 32'h0;
  assign i_rdata   = i_resp   ? mem_rdata : 32'h0;

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Directed bench for mmu_mem_arbiter: one task per scenario, inline checks.
module tb_mmu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pte_addr, i_addr, d_addr, d_wdata, mem_rdata;
  logic        pte_read, i_read, d_read, d_write, mem_resp;
  logic [3:0]  d_wmask;
  logic [31:0] pte_rdata, i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        pte_resp, i_resp, d_resp, mem_read, mem_write;
  logic [3:0]  mem_wmask;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve;

  int checks = 0;
  int passed = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_PTE = 2'd1, S_DMEM = 2'd2, S_IMEM = 2'd3;

  mmu_mem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .pte_addr(pte_addr), .pte_read(pte_read), .pte_rdata(pte_rdata), .pte_resp(pte_resp),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .dbg_state_o(dbg_state), .dbg_starve_cnt_o(dbg_starve)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pte_addr = '0; pte_read = 0; i_addr = '0; i_read = 0;
    d_addr = '0; d_read = 0; d_write = 0; d_wdata = '0; d_wmask = '0;
    mem_rdata = '0; mem_resp = 0;
    step(); step();
    rst = 1'b0;
    settle();
    checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); else passed++;
    checks++; if (dbg_starve !== 4'd0) $display("FAIL reset_starve: got %0d want 0", dbg_starve); else passed++;
    checks++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL reset_mem_op: got %b want 00", {mem_read, mem_write}); else passed++;
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 4'h0)
      $display("FAIL reset_mem_regs: got addr %h wdata %h wmask %h want zeros", mem_addr, mem_wdata, mem_wmask); else passed++;
    checks++; if ({pte_resp, d_resp, i_resp} !== 3'b000 || (pte_rdata | d_rdata | i_rdata) !== 32'h0)
      $display("FAIL reset_resp: got resp %b want 000", {pte_resp, d_resp, i_resp}); else passed++;
  endtask

  task automatic test_pte_read();
    pte_addr = 32'h8000_1007;
    pte_read = 1'b1;
    settle();
    checks++; if (mem_read !== 1'b0) $display("FAIL pte_grant_cycle_read: got %b want 0", mem_read); else passed++;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        mem_resp = 1'b1;
        mem_rdata = 32'h2000_0C01;
        settle();
      end
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0)
        $display("FAIL pte_mem_op_c%0d: got rd %b wr %b want rd 1 wr 0", c, mem_read, mem_write); else passed++;
      checks++; if (mem_addr !== 32'h8000_1004) $display("FAIL pte_addr_c%0d: got %h want 80001004", c, mem_addr); else passed++;
      checks++; if (pte_resp !== (c == 3)) $display("FAIL pte_resp_c%0d: got %b want %b", c, pte_resp, (c == 3)); else passed++;
    end
    checks++; if (pte_rdata !== 32'h2000_0C01) $display("FAIL pte_rdata: got %h want 20000c01", pte_rdata); else passed++;
    checks++; if (d_resp !== 1'b0 || i_resp !== 1'b0 || d_rdata !== 32'h0)
      $display("FAIL pte_other_resp: got d %b i %b drdata %h want 0", d_resp, i_resp, d_rdata); else passed++;
    step();
    pte_read = 1'b0;
    mem_resp = 1'b0;
    settle();
    checks++; if (mem_read !== 1'b0 || pte_resp !== 1'b0 || dbg_state !== S_IDLE)
      $display("FAIL pte_after: got rd %b resp %b state %0d want 0 0 0", mem_read, pte_resp, dbg_state); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_addr [3];
    logic [2:0]  exp_vec [3];
    logic [3:0]  exp_starve [3];
    logic [31:0] got_rdata;
    exp_addr[0] = 32'h8000_2000; exp_vec[0] = 3'b100; exp_starve[0] = 4'd1;
    exp_addr[1] = 32'h1000_0020; exp_vec[1] = 3'b010; exp_starve[1] = 4'd2;
    exp_addr[2] = 32'h0000_0400; exp_vec[2] = 3'b001; exp_starve[2] = 4'd0;
    pte_addr = 32'h8000_2003; d_addr = 32'h1000_0020; i_addr = 32'h0000_0400;
    pte_read = 1; d_read = 1; i_read = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (mem_addr !== exp_addr[k] || mem_read !== 1'b1)
        $display("FAIL simul_grant%0d: got addr %h rd %b want %h 1", k, mem_addr, mem_read, exp_addr[k]); else passed++;
      checks++; if (dbg_starve !== exp_starve[k])
        $display("FAIL simul_starve%0d: got %0d want %0d", k, dbg_starve, exp_starve[k]); else passed++;
      checks++; if ({pte_resp, d_resp, i_resp} !== 3'b000)
        $display("FAIL simul_early_resp%0d: got %b want 000", k, {pte_resp, d_resp, i_resp}); else passed++;
      step();
      mem_resp = 1'b1;
      mem_rdata = 32'hA000_0000 + k;
      settle();
      checks++; if ({pte_resp, d_resp, i_resp} !== exp_vec[k])
        $display("FAIL simul_resp%0d: got %b want %b", k, {pte_resp, d_resp, i_resp}, exp_vec[k]); else passed++;
      got_rdata = (k == 0) ? pte_rdata : (k == 1) ? d_rdata : i_rdata;
      checks++; if (got_rdata !== 32'hA000_0000 + k)
        $display("FAIL simul_rdata%0d: got %h want %h", k, got_rdata, 32'hA000_0000 + k); else passed++;
      step();
      mem_resp = 1'b0;
      if (k == 0) pte_read = 0;
      if (k == 1) d_read = 0;
      if (k == 2) i_read = 0;
      settle();
      checks++; if ({pte_resp, d_resp, i_resp} !== 3'b000 || mem_read !== 1'b0)
        $display("FAIL simul_idle%0d: got resp %b rd %b want 000 0", k, {pte_resp, d_resp, i_resp}, mem_read); else passed++;
    end
    step();
    checks++; if (dbg_state !== S_IDLE) $display("FAIL simul_end_state: got %0d want 0", dbg_state); else passed++;
  endtask

  task automatic test_dwrite();
    d_addr = 32'h1000_0010; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011; d_write = 1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        mem_resp = 1'b1;
        mem_rdata = 32'h1234_5678;
        settle();
      end
      checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0)
        $display("FAIL dwr_op_c%0d: got wr %b rd %b want 1 0", c, mem_write, mem_read); else passed++;
      checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'b0011 || mem_addr !== 32'h1000_0010)
        $display("FAIL dwr_data_c%0d: got %h %b %h want deadbeef 0011 10000010", c, mem_wdata, mem_wmask, mem_addr); else passed++;
    end
    checks++; if (d_resp !== 1'b1 || pte_resp !== 1'b0 || i_resp !== 1'b0)
      $display("FAIL dwr_resp: got d %b p %b i %b want 1 0 0", d_resp, pte_resp, i_resp); else passed++;
    step();
    d_write = 0; d_wmask = 4'h0; mem_resp = 0;
    settle();
    checks++; if (mem_write !== 1'b0 || mem_wmask !== 4'h0 || d_resp !== 1'b0)
      $display("FAIL dwr_after: got wr %b wmask %b resp %b want 0 0000 0", mem_write, mem_wmask, d_resp); else passed++;
  endtask

  task automatic test_starvation();
    d_addr = 32'h1000_0040; i_addr = 32'h0000_0800;
    d_read = 1; i_read = 1;
    for (int g = 1; g <= 9; g++) begin
      step();
      checks++; if (mem_addr !== ((g == 9) ? 32'h0000_0800 : 32'h1000_0040))
        $display("FAIL starve_grant%0d: got %h want %h", g, mem_addr, (g == 9) ? 32'h0000_0800 : 32'h1000_0040); else passed++;
      checks++; if (dbg_starve !== ((g == 9) ? 4'd0 : 4'(g)))
        $display("FAIL starve_cnt%0d: got %0d want %0d", g, dbg_starve, (g == 9) ? 0 : g); else passed++;
      mem_resp = 1'b1;
      mem_rdata = 32'hC000_0000 + g;
      settle();
      checks++; if ({d_resp, i_resp} !== ((g == 9) ? 2'b01 : 2'b10))
        $display("FAIL starve_resp%0d: got %b want %b", g, {d_resp, i_resp}, (g == 9) ? 2'b01 : 2'b10); else passed++;
      step();
      mem_resp = 1'b0;
      if (g == 9) begin
        d_read = 0;
        i_read = 0;
      end
      settle();
    end
    step();
    checks++; if (dbg_state !== S_IDLE || dbg_starve !== 4'd0)
      $display("FAIL starve_end: got state %0d cnt %0d want 0 0", dbg_state, dbg_starve); else passed++;
  endtask

  task automatic test_drop_before_grant();
    d_addr = 32'h1000_0080; i_addr = 32'h0000_0C00; d_read = 1;
    step();
    i_read = 1;
    step();
    i_read = 0;
    mem_resp = 1;
    mem_rdata = 32'h5555_AAAA;
    settle();
    checks++; if (d_resp !== 1'b1 || d_rdata !== 32'h5555_AAAA)
      $display("FAIL drop_dresp: got %b %h want 1 5555aaaa", d_resp, d_rdata); else passed++;
    step();
    d_read = 0;
    mem_resp = 0;
    settle();
    step();
    checks++; if (dbg_state !== S_IDLE || mem_read !== 1'b0)
      $display("FAIL drop_no_service: got state %0d rd %b want 0 0", dbg_state, mem_read); else passed++;
  endtask

  task automatic test_reset_mid();
    pte_addr = 32'h8000_3000; pte_read = 1;
    step();
    checks++; if (dbg_state !== S_PTE || mem_read !== 1'b1)
      $display("FAIL rstmid_busy: got state %0d rd %b want 1 1", dbg_state, mem_read); else passed++;
    rst = 1; pte_read = 0;
    step();
    rst = 0;
    settle();
    checks++; if (mem_read !== 1'b0 || mem_addr !== 32'h0 || dbg_state !== S_IDLE)
      $display("FAIL rstmid_cleared: got rd %b addr %h state %0d want 0 0 0", mem_read, mem_addr, dbg_state); else passed++;
    mem_resp = 1; mem_rdata = 32'h7777_7777;
    settle();
    checks++; if ({pte_resp, d_resp, i_resp} !== 3'b000 || pte_rdata !== 32'h0)
      $display("FAIL rstmid_late_resp: got %b %h want 000 0", {pte_resp, d_resp, i_resp}, pte_rdata); else passed++;
    step();
    mem_resp = 0;
    settle();
    checks++; if (dbg_state !== S_IDLE || mem_read !== 1'b0)
      $display("FAIL rstmid_after: got state %0d rd %b want 0 0", dbg_state, mem_read); else passed++;
  endtask

  task automatic test_idle_resp();
    mem_resp = 1; mem_rdata = 32'hFFFF_0000;
    settle();
    checks++; if ({pte_resp, d_resp, i_resp} !== 3'b000 || (pte_rdata | d_rdata | i_rdata) !== 32'h0)
      $display("FAIL idle_resp_out: got %b want 000", {pte_resp, d_resp, i_resp}); else passed++;
    step();
    mem_resp = 0;
    settle();
    checks++; if (dbg_state !== S_IDLE || mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL idle_resp_state: got state %0d rd %b wr %b want 0 0 0", dbg_state, mem_read, mem_write); else passed++;
  endtask

  initial begin
    test_reset();
    test_pte_read();
    test_simultaneous();
    test_dwrite();
    test_starvation();
    test_drop_before_grant();
    test_reset_mid();
    test_idle_resp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mmu_mem_arbiter.md
MMU_MEM_ARBITER -- requirements
Module: mmu_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, is the number of consecutive lost arbitrations after which the instruction port gets top priority.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pte_addr  in  32  MMU page-table-entry address; bits[1:0] ignored and forced 0 on memory side.
REQ-005 pte_read  in  1  MMU PTE read request; held until pte_resp.
REQ-006 pte_rdata  out  32  PTE data returned to MMU (pte_in of MMU).
REQ-007 pte_resp  out  1  one-cycle completion pulse to MMU (mem_resp of MMU).
REQ-008 i_addr  in  32  instruction fetch physical address; i_read  in  1  fetch request.
REQ-009 i_rdata  out  32  fetch data; i_resp  out  1  fetch completion pulse.
REQ-010 d_addr  in  32  data physical address; d_read, d_write  in  1 each  data request (never both high).
REQ-011 d_wdata  in  32  store data; d_wmask  in  4  byte enables.
REQ-012 d_rdata  out  32  load data; d_resp  out  1  data completion pulse.
REQ-013 mem_addr  out  32; mem_read, mem_write  out  1; mem_wdata  out  32; mem_wmask  out  4  single downstream memory port.
REQ-014 mem_rdata  in  32; mem_resp  in  1  downstream completion, arbitrary latency >= 1 cycle.

Function
REQ-015 FSM states: IDLE, PTE, DMEM, IMEM; exactly one transaction outstanding on mem port at a time.
REQ-016 In IDLE, grant priority: pte_read > d_read|d_write > i_read; override: if starve_cnt == STARVE_LIMIT and i_read, IMEM wins over D (PTE still wins).
REQ-017 On grant in cycle N, addr/wdata/wmask/op are captured in registers; mem_read/mem_write assert from cycle N+1 and stay stable until the cycle mem_resp is sampled high.
REQ-018 mem_addr for PTE grant = {pte_addr[31:2], 2'b00}; mem_write never asserted for PTE or IMEM grants; mem_wmask = 0 when not writing.
REQ-019 Response path is combinational: in the cycle mem_resp=1, the granted port's resp = 1 and its rdata = mem_rdata; other resp outputs are 0; non-granted rdata outputs hold 0.
REQ-020 Cycle after mem_resp: FSM returns to IDLE, mem_read/mem_write = 0; minimum request-to-resp latency is 2 cycles (grant + one memory cycle).
REQ-021 Requesters deassert their request in the cycle following their resp; a request still high in IDLE is treated as a new transaction.
REQ-022 Requests arriving while not IDLE wait; a request dropped before grant is not serviced.
REQ-023 starve_cnt (width clog2(STARVE_LIMIT+1)): increments, saturating at STARVE_LIMIT, on each IDLE grant made to another port while i_read=1; cleared on IMEM grant or when i_read=0 in IDLE.
REQ-024 Simultaneous pte_read, d_read, i_read in IDLE: PTE granted; D then I served in subsequent transactions in that order (absent starvation override).
REQ-025 mem_resp while in IDLE is ignored (no resp pulse, no state change).

Reset
REQ-026 On rst: state = IDLE, starve_cnt = 0, captured regs = 0, all mem_* and *_resp outputs 0, all rdata outputs 0.
REQ-027 rst mid-transaction abandons it: no resp pulse is issued for it, and a mem_resp in the cycle after reset is ignored.

Structure
REQ-028 Shared package mmu_pkg holds arb_state_t enum (IDLE, PTE, DMEM, IMEM) and default STARVE_LIMIT constant.
REQ-029 Single module; no sub-module (capture registers and counter are inline).

Verification
REQ-030 pte_read=1, pte_addr=0x8000_1007, mem_resp after 3 cycles with rdata 0x2000_0C01 -> mem_addr=0x8000_1004, mem_read high 3 cycles, pte_resp pulse with pte_rdata=0x2000_0C01.
REQ-031 pte_read, d_read, i_read asserted same cycle -> grant order PTE, DMEM, IMEM; exactly three resp pulses, one per port, none overlapping.
REQ-032 d_write with d_wdata=0xDEAD_BEEF, d_wmask=4'b0011 -> mem_write=1, mem_wdata=0xDEAD_BEEF, mem_wmask=4'b0011 stable until mem_resp; d_resp on that cycle.
REQ-033 i_read held while d_read re-issued every transaction, STARVE_LIMIT=8 -> 9th grant goes to IMEM, starve_cnt then 0.
REQ-034 rst pulsed in PTE state before mem_resp -> outputs 0 next cycle, no pte_resp, late mem_resp ignored.
REQ-035 mem_resp=1 in IDLE with no request -> no resp outputs, state stays IDLE.
